// File: rtl/pad_share_if.sv
// Pad-sharing bus: owner-select handshake, per-source pad inputs and pad-ring outputs.
interface pad_share_if #(
  parameter int unsigned NO_PADS = 16,
  parameter int unsigned NO_SRC  = 4,
  parameter int unsigned SELW    = 3
);

  logic [SELW-1:0]           sel_i;
  logic                      sel_valid_i;
  logic                      sel_ready_o;
  logic [NO_SRC*NO_PADS-1:0] src_out_i;
  logic [NO_SRC*NO_PADS-1:0] src_oeb_i;
  logic [NO_PADS-1:0]        io_out_o;
  logic [NO_PADS-1:0]        io_oeb_o;
  logic [NO_SRC-1:0]         src_en_o;
  logic [SELW-1:0]           cur_sel_o;
  logic                      busy_o;

  // Requester / sub-design side
  modport master (
    output sel_i, sel_valid_i, src_out_i, src_oeb_i,
    input  sel_ready_o, io_out_o, io_oeb_o, src_en_o, cur_sel_o, busy_o
  );

  // Controller side
  modport slave (
    input  sel_i, sel_valid_i, src_out_i, src_oeb_i,
    output sel_ready_o, io_out_o, io_oeb_o, src_en_o, cur_sel_o, busy_o
  );

endinterface

// File: rtl/pad_share_ctrl.sv
// Pad-sharing controller: hands the shared user pads to one source at a time,
// with an all-tristate guard window on every ownership change.
module pad_share_ctrl #(
  parameter int unsigned NO_PADS = 16,
  parameter int unsigned NO_SRC  = 4,
  parameter int unsigned SELW    = 3,
  parameter int unsigned GUARD   = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  pad_share_if.slave  bus
);

  localparam int unsigned     CNTW     = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [SELW-1:0] PARK_SEL = SELW'(NO_SRC);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_PARK,
    ST_ACTIVE,
    ST_GUARD
  } state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] owner_q, owner_d;
  logic [SELW-1:0] target_q, target_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic [SELW-1:0] req_sel;

  // Out-of-range request codes collapse onto the park code
  always_comb begin
    req_sel = (bus.sel_i >= PARK_SEL) ? PARK_SEL : bus.sel_i;
  end

  // Next-state logic: accept requests outside GUARD, count down the guard window
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    accept   = bus.sel_valid_i && (state_q != ST_GUARD);
    case (state_q)
      ST_PARK: begin
        if (accept && (req_sel != PARK_SEL)) begin
          state_d  = ST_GUARD;
          target_d = req_sel;
          cnt_d    = CNT_LOAD;
        end
      end
      ST_ACTIVE: begin
        if (accept && (req_sel != owner_q)) begin
          state_d  = ST_GUARD;
          target_d = req_sel;
          cnt_d    = CNT_LOAD;
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) begin
          owner_d = target_q;
          state_d = (target_q == PARK_SEL) ? ST_PARK : ST_ACTIVE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: begin
        state_d = ST_PARK;
        owner_d = PARK_SEL;
      end
    endcase
  end

  // State, owner, target and counter registers; reset discards any pending switch
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_PARK;
      owner_q  <= PARK_SEL;
      target_q <= PARK_SEL;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode: pads follow the registered owner only in ACTIVE, safe defaults otherwise
  always_comb begin
    bus.io_out_o    = '0;
    bus.io_oeb_o    = '1;
    bus.src_en_o    = '0;
    bus.cur_sel_o   = PARK_SEL;
    bus.busy_o      = 1'b0;
    bus.sel_ready_o = 1'b1;
    if (state_q == ST_ACTIVE) begin
      bus.cur_sel_o = owner_q;
      for (int unsigned k = 0; k < NO_SRC; k++) begin
        if (owner_q == SELW'(k)) begin
          bus.io_out_o    = bus.src_out_i[k*NO_PADS +: NO_PADS];
          bus.io_oeb_o    = bus.src_oeb_i[k*NO_PADS +: NO_PADS];
          bus.src_en_o[k] = 1'b1;
        end
      end
    end
    if (state_q == ST_GUARD) begin
      bus.busy_o      = 1'b1;
      bus.sel_ready_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_pad_share_ctrl.sv
// Bench for pad_share_ctrl: directed scenarios plus random traffic against an ownership model.
module tb_pad_share_ctrl;

  localparam int NO_PADS = 16;
  localparam int NO_SRC  = 4;
  localparam int SELW    = 3;
  localparam int GUARD   = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: current owner (NO_SRC = nobody), remaining guard cycles, pending owner
  int   m_owner;
  int   m_guard_left;
  int   m_pend;
  bit   m_known = 1'b0;

  pad_share_if #(.NO_PADS(NO_PADS), .NO_SRC(NO_SRC), .SELW(SELW)) bus ();

  pad_share_ctrl #(
    .NO_PADS(NO_PADS), .NO_SRC(NO_SRC), .SELW(SELW), .GUARD(GUARD)
  ) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output with what the model says the pad bank should look like now
  task automatic check_all();
    logic [NO_PADS-1:0] e_out, e_oeb;
    logic [NO_SRC-1:0]  e_en;
    int                 e_cur;
    logic               e_busy;
    e_out  = '0;
    e_oeb  = '1;
    e_en   = '0;
    e_cur  = NO_SRC;
    e_busy = (m_guard_left > 0);
    if (!e_busy && m_owner < NO_SRC) begin
      e_out = bus.src_out_i[m_owner*NO_PADS +: NO_PADS];
      e_oeb = bus.src_oeb_i[m_owner*NO_PADS +: NO_PADS];
      e_en  = NO_SRC'(1 << m_owner);
      e_cur = m_owner;
    end
    chk("io_out",    64'(bus.io_out_o),    64'(e_out));
    chk("io_oeb",    64'(bus.io_oeb_o),    64'(e_oeb));
    chk("src_en",    64'(bus.src_en_o),    64'(e_en));
    chk("cur_sel",   64'(bus.cur_sel_o),   64'(e_cur));
    chk("busy",      64'(bus.busy_o),      64'(e_busy));
    chk("sel_ready", 64'(bus.sel_ready_o), 64'(!e_busy));
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    int t;
    if (rst) begin
      m_owner      = NO_SRC;
      m_guard_left = 0;
      m_pend       = NO_SRC;
      m_known      = 1'b1;
    end else if (m_known) begin
      if (m_guard_left > 0) begin
        m_guard_left--;
        if (m_guard_left == 0) m_owner = m_pend;
      end else if (bus.sel_valid_i) begin
        t = (int'(bus.sel_i) >= NO_SRC) ? NO_SRC : int'(bus.sel_i);
        if (t != m_owner) begin
          m_pend       = t;
          m_owner      = NO_SRC;
          m_guard_left = GUARD;
        end
      end
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then take the edge
  task automatic do_cycle(input logic r, input logic v, input logic [SELW-1:0] s,
                          input logic [NO_SRC*NO_PADS-1:0] so,
                          input logic [NO_SRC*NO_PADS-1:0] se);
    rst             = r;
    bus.sel_valid_i = v;
    bus.sel_i       = s;
    bus.src_out_i   = so;
    bus.src_oeb_i   = se;
    @(negedge clk);
    if (m_known) check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [NO_SRC*NO_PADS-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, SELW'($urandom), rnd64(), rnd64());
  endtask

  task automatic req(input logic [SELW-1:0] s);
    do_cycle(1'b0, 1'b1, s, rnd64(), rnd64());
  endtask

  initial begin
    rst = 1'b1;
    bus.sel_valid_i = 1'b0;
    bus.sel_i = '0;
    bus.src_out_i = '0;
    bus.src_oeb_i = '0;
    #1;

    // Reset defaults with all sources driving ones and enabled
    do_cycle(1'b1, 1'b0, '0, '1, '0);
    do_cycle(1'b1, 1'b1, 3'd2, '1, '0);
    do_cycle(1'b0, 1'b0, '0, '1, '0);
    chk("rst_io_oeb", 64'(bus.io_oeb_o), 64'hFFFF);
    chk("rst_cur_sel", 64'(bus.cur_sel_o), 64'(NO_SRC));

    // Park -> source 2, then source 2 -> source 0
    req(3'd2);
    idle(GUARD + 2);
    chk("own2_src_en", 64'(bus.src_en_o), 64'b0100);
    req(3'd0);
    idle(GUARD + 2);
    chk("own0_src_en", 64'(bus.src_en_o), 64'b0001);

    // No-op request for the current owner, then an out-of-range code parks
    req(3'd1);
    idle(GUARD + 2);
    for (int i = 0; i < 4; i++) req(3'd1);
    req(3'd7);
    idle(GUARD + 2);
    chk("park_cur_sel", 64'(bus.cur_sel_o), 64'(NO_SRC));

    // Backpressure: request 3 held throughout a guard window
    req(3'd2);
    for (int i = 0; i < 2 * GUARD + 6; i++) req(3'd3);
    chk("bp_src_en", 64'(bus.src_en_o), 64'b1000);
    idle(2);

    // Reset in the middle of a guard window drops the pending target
    req(3'd1);
    idle(4);
    do_cycle(1'b1, 1'b1, 3'd1, rnd64(), rnd64());
    idle(GUARD + 3);
    chk("midrst_cur_sel", 64'(bus.cur_sel_o), 64'(NO_SRC));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      do_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
               SELW'($urandom_range(0, 7)), rnd64(), rnd64());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_share_ctrl.md
# pad_share_ctrl

Pad-sharing controller for the user-project IO bank. It hands a common set of user IO pads to exactly one of several sub-designs at a time, or to none ("park").

- On every ownership change it tristates all pads for a programmable guard interval before the new owner's drivers are connected. Two sub-designs therefore never drive a pad in the same cycle.
- It sits between the sub-design instances and the pad ring.
- Its parked state gives the same safe defaults the tie cells provide: out = 0, oeb = 1.

## Interface

Parameters:
- NO_PADS, 16: number of shared pads.
- NO_SRC, 4: number of sub-designs (sources); at least 1.
- SELW, 3: select width; must satisfy 2^SELW > NO_SRC.
- GUARD, 8: tristate guard length in cycles; at least 1.

Ports:
- wb_clk_i, in, 1: single clock; all state changes on the rising edge.
- wb_rst_i, in, 1: synchronous, active-high reset.
- sel_i, in, SELW: requested owner. Values 0..NO_SRC-1 select a source; any value ≥ NO_SRC means park.
- sel_valid_i, in, 1: request valid.
- sel_ready_o, out, 1: controller can accept a request.
- src_out_i, in, NO_SRC*NO_PADS: per-source pad outputs; source k occupies bits [k*NO_PADS +: NO_PADS].
- src_oeb_i, in, NO_SRC*NO_PADS: per-source output-enable-bar, same packing as src_out_i.
- io_out_o, out, NO_PADS: to pad ring.
- io_oeb_o, out, NO_PADS: to pad ring; 1 = input/tristate.
- src_en_o, out, NO_SRC: one-hot "you own the pads" enable; all zero when no source owns the pads.
- cur_sel_o, out, SELW: current owner code. NO_SRC means parked or switching.
- busy_o, out, 1: high while in GUARD.

## Operation

States: PARK, ACTIVE, GUARD.
- **PARK:** no owner; io_out_o = 0, io_oeb_o = all 1, src_en_o = 0, cur_sel_o = NO_SRC.
- **ACTIVE:** owner k; io_out_o = src_out_i[k], io_oeb_o = src_oeb_i[k], src_en_o = 1<<k, cur_sel_o = k.
- **GUARD:** pads forced as in PARK; src_en_o = 0; cur_sel_o = NO_SRC; a down-counter runs; the pending target is held in a register.

Handshake:
- sel_ready_o = 1 in PARK and ACTIVE, 0 in GUARD.
- A request is accepted on an edge where sel_valid_i & sel_ready_o.
- Requests presented during GUARD wait; there is no queue. sel_i must be held until accepted.

Transitions on acceptance:
- ACTIVE(k), request for k: accepted, no-op, stay in ACTIVE(k). No guard, no glitch on any output.
- PARK, request for park: accepted, no-op.
- Any other accepted request: go to GUARD, counter loaded with GUARD-1, target latched. Out-of-range codes are normalised to park.
- GUARD with counter = 0: next state is ACTIVE(target), or PARK if the target is park. Otherwise the counter decrements.

Rules:
- The pad datapath is combinational from the registered owner. Pad values follow source inputs with zero latency while ACTIVE.
- The owner register, state, counter and target are the only storage. All outputs other than the pad data are decoded from these registers and are glitch-free.
- The counter width is $clog2(GUARD) bits, minimum 1.

## Timing

Reset:
- wb_rst_i high at an edge gives PARK on the next cycle from any state, including mid-GUARD.
- The counter is cleared and any pending target is discarded.
- Output values in reset: io_out_o = 0, io_oeb_o = all 1, src_en_o = 0, cur_sel_o = NO_SRC, busy_o = 0, sel_ready_o = 1.

Switch timing, with the request accepted at edge E:
- From cycle E+1, pads are tristated and src_en_o = 0.
- Pads stay tristated for exactly GUARD cycles: E+1 through E+GUARD.
- The new owner drives from cycle E+GUARD+1; src_en_o and cur_sel_o update in the same cycle.
- sel_ready_o is 0 during cycles E+1 through E+GUARD, so the earliest next acceptance is at edge E+GUARD+1.

Boundaries:
- GUARD = 1 gives a single-cycle tristate window.
- A request on the same cycle as wb_rst_i is ignored; reset has priority.
- sel_valid_i high continuously with the same code produces repeated no-op accepts.

## Test plan

- **Reset defaults:** assert wb_rst_i 2 cycles with src_out_i all 1 and src_oeb_i all 0 → io_out_o = 0, io_oeb_o = 16'hFFFF, src_en_o = 0, cur_sel_o = 4, sel_ready_o = 1.
- **Park to source:** from PARK, request sel = 2 (GUARD = 8) → tristated for 8 cycles with busy_o = 1; then io_out_o = source-2 bits, src_en_o = 4'b0100, cur_sel_o = 2.
- **Source to source:** from ACTIVE(2), request 0 → src_en_o drops the cycle after acceptance, 8 tristate cycles, then src_en_o = 4'b0001. No cycle has source 2 and source 0 both enabled.
- **No-op and invalid codes:**
  - From ACTIVE(1), request 1 → accepted, busy_o stays 0, outputs unchanged.
  - Request 7 → GUARD, then PARK with cur_sel_o = 4.
- **Backpressure:** during GUARD, hold sel_valid_i = 1 with sel = 3 → sel_ready_o = 0 throughout GUARD; request accepted on the first ACTIVE/PARK cycle, then a second GUARD, then ACTIVE(3).
- **Reset mid-guard:** assert wb_rst_i at GUARD count 4 → PARK next cycle, pending target dropped, cur_sel_o = 4.
